enable_map_ctrl: RTL and testbench

- Parametrised successor to the single-table RAM/bus enable lookup.
- Holds 2^CONFIG_BITS selectable enable maps at configurable page granularity, with separate read and write entries per page and a write-protect bit per entry.
- Reset clears the table to a default entry automatically; a valid/ready stream port reloads it at run time.
- Sits between the CPU address/phi2 bus and the RAM/bus chip-select logic.

---
 rtl/enable_map_ctrl.sv | 156 +++++++++++++++
 tb/tb_enable_map_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enable_map_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : enable_map_ctrl
// Description : Paged RAM/bus enable lookup. It holds 2^CONFIG_BITS selectable
//               maps, with separate read and write entries per page. After
//               reset the table is filled with a default entry, and it can be
//               reloaded at run time through a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module enable_map_ctrl #(
  parameter int         ADDR_WIDTH    = 16,
  parameter int         GRAN_BITS     = 8,
  parameter int         CONFIG_BITS   = 2,
  parameter logic [2:0] DEFAULT_ENTRY = 3'b001
) (
  input  logic                                      fpga_clk,
  input  logic                                      reset_n,
  input  logic [ADDR_WIDTH-1:0]                     address,
  input  logic                                      phi2,
  input  logic                                      rwbar,
  input  logic                                      mreq,
  input  logic [CONFIG_BITS-1:0]                    config_sel,
  input  logic                                      cfg_update,
  input  logic                                      ld_start,
  input  logic [CONFIG_BITS+ADDR_WIDTH-GRAN_BITS:0] ld_base,
  input  logic                                      ld_valid,
  input  logic [2:0]                                ld_data,
  input  logic                                      ld_last,
  output logic                                      ld_ready,
  output logic                                      busy,
  output logic [CONFIG_BITS-1:0]                    active_config,
  output logic                                      cs_ram,
  output logic                                      cs_bus,
  output logic                                      we,
  output logic                                      wp_violation
);

  localparam int IDX_W = CONFIG_BITS + 1 + ADDR_WIDTH - GRAN_BITS;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [IDX_W-1:0]         ptr;
  logic [2:0]               outval;
  logic [2:0]               table_mem [DEPTH];
  logic [CONFIG_BITS-1:0]   pending;
  logic                     pending_flag;
  logic [IDX_W-1:0]         lookup_idx;
  logic                     gate;
  logic                     apply_cfg;
  logic                     tbl_we;
  logic [2:0]               tbl_wdata;
  logic                     addr_lo_unused;

  // Byte offset within a page does not affect the lookup.
  assign addr_lo_unused = ^address[GRAN_BITS-1:0];

  assign lookup_idx = {active_config, rwbar, address[ADDR_WIDTH-1:GRAN_BITS]};
  assign gate       = (state == ST_RUN);
  assign apply_cfg  = pending_flag & ~phi2 & gate;

  // Next state, table write request and bus-facing outputs.
  always_comb begin
    state_nxt = state;
    tbl_we    = 1'b0;
    tbl_wdata = DEFAULT_ENTRY;
    ld_ready  = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_INIT: begin
        tbl_we = 1'b1;
        if (ptr == LAST_IDX) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b0;
        if (ld_start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          tbl_we    = 1'b1;
          tbl_wdata = ld_data;
          if (ld_last) state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
    cs_ram = gate & phi2 & mreq & outval[1];
    cs_bus = (gate & phi2 & outval[0]) | ~mreq;
    we     = gate & phi2 & ~rwbar & ~outval[2];
  end

  // State register; reset restarts the default fill.
  always_ff @(posedge fpga_clk or negedge reset_n) begin
    if (!reset_n) state <= ST_INIT;
    else          state <= state_nxt;
  end

  // Table pointer: walks the whole table in INIT, follows accepted beats in LOAD.
  always_ff @(posedge fpga_clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else begin
      case (state)
        ST_INIT: ptr <= ptr + IDX_ONE;
        ST_RUN:  if (ld_start) ptr <= ld_base;
        ST_LOAD: if (ld_valid) ptr <= ptr + IDX_ONE;
        default: ptr <= '0;
      endcase
    end
  end

  // Table storage, written during fill and reload only.
  always_ff @(posedge fpga_clk) begin
    if (tbl_we) table_mem[ptr] <= tbl_wdata;
  end

  // Registered lookup; frozen outside RUN so reloads do not disturb the bus.
  always_ff @(posedge fpga_clk or negedge reset_n) begin
    if (!reset_n)   outval <= 3'b000;
    else if (gate)  outval <= table_mem[lookup_idx];
  end

  // Map switch is deferred to a phi2-low RUN cycle; a same-edge update stays pending.
  always_ff @(posedge fpga_clk or negedge reset_n) begin
    if (!reset_n) begin
      active_config <= '0;
      pending       <= '0;
      pending_flag  <= 1'b0;
    end else begin
      if (apply_cfg) active_config <= pending;
      if (cfg_update) begin
        pending      <= config_sel;
        pending_flag <= 1'b1;
      end else if (apply_cfg) begin
        pending_flag <= 1'b0;
      end
    end
  end

  // Flag a CPU write that hit a write-protected page.
  always_ff @(posedge fpga_clk or negedge reset_n) begin
    if (!reset_n) wp_violation <= 1'b0;
    else          wp_violation <= phi2 & ~rwbar & mreq & gate & outval[2];
  end

endmodule
`default_nettype wire

// File: tb/tb_enable_map_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_enable_map_ctrl
// Description : Self-checking bench for enable_map_ctrl with a table model and
//               an expectation queue for bus lookups.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enable_map_ctrl;

  localparam int         IW    = 11;
  localparam int         DEPTH = 2048;
  localparam logic [2:0] DEF   = 3'b001;

  logic          fpga_clk = 1'b0;
  logic          reset_n  = 1'b0;
  logic [15:0]   address  = 16'h0000;
  logic          phi2     = 1'b0;
  logic          rwbar    = 1'b1;
  logic          mreq     = 1'b1;
  logic [1:0]    config_sel = 2'd0;
  logic          cfg_update = 1'b0;
  logic          ld_start   = 1'b0;
  logic [IW-1:0] ld_base    = '0;
  logic          ld_valid   = 1'b0;
  logic [2:0]    ld_data    = 3'b000;
  logic          ld_last    = 1'b0;
  logic          ld_ready;
  logic          busy;
  logic [1:0]    active_config;
  logic          cs_ram;
  logic          cs_bus;
  logic          we;
  logic          wp_violation;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [2:0]  model [DEPTH];
  logic [1:0]  cur_cfg;
  logic [3:0]  exp_q [$];

  enable_map_ctrl dut (
    .fpga_clk      (fpga_clk),
    .reset_n       (reset_n),
    .address       (address),
    .phi2          (phi2),
    .rwbar         (rwbar),
    .mreq          (mreq),
    .config_sel    (config_sel),
    .cfg_update    (cfg_update),
    .ld_start      (ld_start),
    .ld_base       (ld_base),
    .ld_valid      (ld_valid),
    .ld_data       (ld_data),
    .ld_last       (ld_last),
    .ld_ready      (ld_ready),
    .busy          (busy),
    .active_config (active_config),
    .cs_ram        (cs_ram),
    .cs_bus        (cs_bus),
    .we            (we),
    .wp_violation  (wp_violation)
  );

  always #5 fpga_clk = ~fpga_clk;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = DEF;
    cur_cfg = 2'd0;
  endtask

  // Present a CPU access (phi2=1, mreq=1) and queue the expected
  // {cs_ram, cs_bus, we, wp_violation} derived from the table model.
  task automatic drive_lookup(input logic [15:0] a, input logic rw);
    logic [2:0] ent;
    ent = model[{cur_cfg, rw, a[15:8]}];
    address = a;
    rwbar   = rw;
    phi2    = 1'b1;
    mreq    = 1'b1;
    exp_q.push_back({ent[1], ent[0], ~rw & ~ent[2], ~rw & ent[2]});
    @(negedge fpga_clk);
  endtask

  // Stream a load; n_drive < n_total stops early without ld_last.
  task automatic do_load(input logic [IW-1:0] base, input logic [2:0] data,
                         input int n_total, input int n_drive);
    logic [IW-1:0] p;
    ld_start = 1'b1;
    ld_base  = base;
    ld_valid = 1'b1;
    ld_data  = ~data;
    @(negedge fpga_clk);
    ld_start = 1'b0;
    for (int i = 0; i < n_drive; i++) begin
      ld_valid = 1'b1;
      ld_data  = data;
      ld_last  = (i == n_total - 1);
      ld_start = (i == 1);
      ld_base  = '0;
      @(negedge fpga_clk);
      ld_start = 1'b0;
      p = base + IW'(i);
      model[p] = data;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic switch_cfg(input logic [1:0] sel);
    phi2       = 1'b0;
    cfg_update = 1'b1;
    config_sel = sel;
    @(negedge fpga_clk);
    cfg_update = 1'b0;
    @(negedge fpga_clk);
    cur_cfg = sel;
  endtask

  // Count busy cycles after reset release; reset must be released on a negedge.
  task automatic run_init();
    int cnt;
    cnt  = 0;
    mreq = 1'b0;
    while (busy === 1'b1 && cnt < 5000) begin
      if (cnt == 10) begin
        n_cmp++;
        if ({cs_ram, cs_bus} !== 2'b01) begin
          n_fail++;
          $display("FAIL init_mreq0 cs_ram/cs_bus got %b%b want 01", cs_ram, cs_bus);
        end
      end
      cnt++;
      @(negedge fpga_clk);
    end
    n_cmp++;
    if (cnt != DEPTH) begin
      n_fail++;
      $display("FAIL init_cycles busy cycles got %0d want %0d", cnt, DEPTH);
    end
    mreq = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] addrs [4];
    logic [3:0]  e4;
    addrs = '{16'h0000, 16'h1234, 16'hC123, 16'hFFFF};
    reset_n = 1'b0;
    phi2 = 1'b1; mreq = 1'b1; rwbar = 1'b1;
    repeat (3) @(negedge fpga_clk);
    n_cmp++;
    if ({busy, ld_ready, wp_violation, cs_ram, cs_bus, we} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_outputs busy/rdy/wpv/ram/bus/we got %b%b%b%b%b%b want 100000",
               busy, ld_ready, wp_violation, cs_ram, cs_bus, we);
    end
    n_cmp++;
    if (active_config !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_cfg active_config got %0d want 0", active_config);
    end
    model_reset();
    reset_n = 1'b1;
    run_init();
    for (int i = 0; i < 4; i++) begin
      drive_lookup(addrs[i], 1'b1);
      e4 = exp_q.pop_front();
      n_cmp++;
      if ({cs_ram, cs_bus, we, wp_violation} !== e4) begin
        n_fail++;
        $display("FAIL default_read %h got %b%b%b%b want %b", addrs[i],
                 cs_ram, cs_bus, we, wp_violation, e4);
      end
    end
  endtask

  task automatic test_load_cfg();
    logic [15:0] addrs [2];
    logic [3:0]  e4;
    addrs = '{16'hC123, 16'hC400};
    do_load(11'h3C0, 3'b010, 4, 4);
    n_cmp++;
    if ({busy, ld_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL load_done busy/ld_ready got %b%b want 00", busy, ld_ready);
    end
    switch_cfg(2'd1);
    n_cmp++;
    if (active_config !== 2'd1) begin
      n_fail++;
      $display("FAIL cfg_apply active_config got %0d want 1", active_config);
    end
    for (int i = 0; i < 2; i++) begin
      drive_lookup(addrs[i], 1'b1);
      e4 = exp_q.pop_front();
      n_cmp++;
      if ({cs_ram, cs_bus, we} !== e4[3:1]) begin
        n_fail++;
        $display("FAIL cfg1_read %h ram/bus/we got %b%b%b want %b", addrs[i],
                 cs_ram, cs_bus, we, e4[3:1]);
      end
    end
  endtask

  task automatic test_cfg_defer();
    phi2 = 1'b1;
    cfg_update = 1'b1; config_sel = 2'd3;
    @(negedge fpga_clk);
    config_sel = 2'd2;
    @(negedge fpga_clk);
    cfg_update = 1'b0;
    repeat (5) @(negedge fpga_clk);
    n_cmp++;
    if (active_config !== 2'd1) begin
      n_fail++;
      $display("FAIL cfg_hold_phi2 active_config got %0d want 1", active_config);
    end
    phi2 = 1'b0;
    @(negedge fpga_clk);
    n_cmp++;
    if (active_config !== 2'd2) begin
      n_fail++;
      $display("FAIL cfg_latest active_config got %0d want 2", active_config);
    end
    phi2 = 1'b1;
    cfg_update = 1'b1; config_sel = 2'd3;
    @(negedge fpga_clk);
    phi2 = 1'b0;
    config_sel = 2'd0;
    @(negedge fpga_clk);
    cfg_update = 1'b0;
    n_cmp++;
    if (active_config !== 2'd3) begin
      n_fail++;
      $display("FAIL cfg_same_edge_old active_config got %0d want 3", active_config);
    end
    @(negedge fpga_clk);
    n_cmp++;
    if (active_config !== 2'd0) begin
      n_fail++;
      $display("FAIL cfg_same_edge_new active_config got %0d want 0", active_config);
    end
    cur_cfg = 2'd0;
  endtask

  task automatic test_write_protect();
    logic [15:0] addrs [3];
    logic        rws   [3];
    logic [3:0]  e4;
    addrs = '{16'hE012, 16'hD000, 16'hE012};
    rws   = '{1'b0, 1'b0, 1'b1};
    do_load(11'h0E0, 3'b110, 1, 1);
    for (int i = 0; i < 3; i++) begin
      drive_lookup(addrs[i], rws[i]);
      e4 = exp_q.pop_front();
      n_cmp++;
      if ({cs_ram, cs_bus, we} !== e4[3:1]) begin
        n_fail++;
        $display("FAIL wp_access %h rw=%b ram/bus/we got %b%b%b want %b", addrs[i], rws[i],
                 cs_ram, cs_bus, we, e4[3:1]);
      end
      @(negedge fpga_clk);
      n_cmp++;
      if (wp_violation !== e4[0]) begin
        n_fail++;
        $display("FAIL wp_violation %h rw=%b got %b want %b", addrs[i], rws[i],
                 wp_violation, e4[0]);
      end
      phi2 = 1'b0;
      @(negedge fpga_clk);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] e4;
    do_load(11'h7FF, 3'b011, 2, 2);
    drive_lookup(16'h0000, 1'b0);
    e4 = exp_q.pop_front();
    n_cmp++;
    if ({cs_ram, cs_bus, we} !== e4[3:1]) begin
      n_fail++;
      $display("FAIL wrap_idx000 ram/bus/we got %b%b%b want %b", cs_ram, cs_bus, we, e4[3:1]);
    end
    switch_cfg(2'd3);
    drive_lookup(16'hFF00, 1'b1);
    e4 = exp_q.pop_front();
    n_cmp++;
    if ({cs_ram, cs_bus, we} !== e4[3:1]) begin
      n_fail++;
      $display("FAIL wrap_idx7ff ram/bus/we got %b%b%b want %b", cs_ram, cs_bus, we, e4[3:1]);
    end
    mreq = 1'b0;
    #1;
    n_cmp++;
    if ({cs_ram, cs_bus} !== 2'b01) begin
      n_fail++;
      $display("FAIL run_mreq0 cs_ram/cs_bus got %b%b want 01", cs_ram, cs_bus);
    end
    mreq = 1'b1;
    @(negedge fpga_clk);
  endtask

  task automatic test_reset_mid_load();
    logic [15:0] addrs [3];
    logic        rws   [3];
    logic [3:0]  e4;
    addrs = '{16'h0000, 16'h0100, 16'h0000};
    rws   = '{1'b1, 1'b1, 1'b0};
    phi2 = 1'b0;
    do_load(11'h100, 3'b111, 4, 2);
    n_cmp++;
    if ({busy, ld_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_load busy/ld_ready got %b%b want 11", busy, ld_ready);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, ld_ready, wp_violation, active_config} !== 5'b10000) begin
      n_fail++;
      $display("FAIL abort_reset busy/rdy/wpv/cfg got %b%b%b%0d want 1000",
               busy, ld_ready, wp_violation, active_config);
    end
    model_reset();
    @(negedge fpga_clk);
    reset_n = 1'b1;
    run_init();
    for (int i = 0; i < 3; i++) begin
      drive_lookup(addrs[i], rws[i]);
      e4 = exp_q.pop_front();
      n_cmp++;
      if ({cs_ram, cs_bus, we} !== e4[3:1]) begin
        n_fail++;
        $display("FAIL reinit_read %h rw=%b ram/bus/we got %b%b%b want %b", addrs[i], rws[i],
                 cs_ram, cs_bus, we, e4[3:1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_cfg();
    test_cfg_defer();
    test_write_protect();
    test_wrap();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
